etherneco_synctimer_master: RTL and testbench

Master-side sync-timer controller for the EtherNeco ring. It periodically requests a sync command packet and supplies its payload bytes: command byte, 64-bit master time, 32-bit offset. It then parses the returning response packet, in which each slave node has written its 32-bit elapsed time at position 9+4*(node-1). From those it computes round-trip time and per-node path delay, and feeds the node-1 delay back as the offset of the next command.

---
 rtl/etherneco_synctimer_master.sv | 239 +++++++++++++++++++++++
 tb/tb_etherneco_synctimer_master.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etherneco_synctimer_master.sv
// Master-side sync-timer controller for the EtherNeco ring.
//
// Periodically asks the framer to send a sync command, serves the command payload
// (command byte, 64-bit master time, 32-bit offset), then parses the returning
// response, in which every slave has written its 32-bit elapsed time. From that it
// derives the round-trip time and the per-node one-way delay. The node-1 delay is
// sent back as the offset of the next command.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   enable_i, period_i     periodic trigger control (period 0 = never trigger)
//   correct_override_i     ask slaves to overwrite rather than slew their time
//   current_time_i         master timer
//   cmd_tx_request_o/ack_i handshake with the framer for the command packet
//   s_cmd_pos_i/valid_i    payload byte request; m_cmd_data_o/valid_o answer one cycle later
//   res_rx_*/s_res_*       response packet framing and byte stream
//   busy_o                 transaction in flight
//   meas_valid_o           pulse: rtt_o/node_delay_o just updated
//   overrun_o, timeout_o   pulses: trigger while busy / transaction aborted
//   rtt_o, node_delay_o    results; node i at bits [32*i +: 32]
module etherneco_synctimer_master #(
    parameter int unsigned TIMER_WIDTH  = 64,
    parameter int unsigned NODE_NUM     = 4,
    parameter int unsigned PERIOD_WIDTH = 32,
    parameter int unsigned TIMEOUT      = 65535,
    parameter int unsigned TX_LATENCY   = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [PERIOD_WIDTH-1:0]  period_i,
    input  logic                     correct_override_i,
    input  logic [TIMER_WIDTH-1:0]   current_time_i,
    output logic                     cmd_tx_request_o,
    input  logic                     cmd_tx_ack_i,
    input  logic [15:0]              s_cmd_pos_i,
    input  logic                     s_cmd_valid_i,
    output logic [7:0]               m_cmd_data_o,
    output logic                     m_cmd_valid_o,
    input  logic                     res_rx_start_i,
    input  logic                     res_rx_end_i,
    input  logic                     res_rx_error_i,
    input  logic [15:0]              s_res_pos_i,
    input  logic [7:0]               s_res_data_i,
    input  logic                     s_res_valid_i,
    output logic                     busy_o,
    output logic                     meas_valid_o,
    output logic                     overrun_o,
    output logic                     timeout_o,
    output logic [31:0]              rtt_o,
    output logic [NODE_NUM*32-1:0]   node_delay_o
);

    localparam int unsigned ToW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StRecv, StCalc} state_e;

    state_e                         state_q, state_d;
    logic [PERIOD_WIDTH-1:0]        period_cnt_q, period_cnt_d;
    logic [ToW-1:0]                 to_cnt_q, to_cnt_d;
    logic [TIMER_WIDTH-1:0]         tx_time_q, tx_time_d;
    logic [7:0]                     cmd_byte_q, cmd_byte_d;
    logic [31:0]                    rtt_raw_q, rtt_raw_d;
    logic [NODE_NUM-1:0][31:0]      elapsed_q, elapsed_d;
    logic [31:0]                    rtt_q, rtt_d;
    logic [NODE_NUM-1:0][31:0]      node_delay_q, node_delay_d;
    logic                           first_done_q, first_done_d;
    logic                           meas_valid_q, meas_valid_d;
    logic                           overrun_q, overrun_d;
    logic                           timeout_q, timeout_d;
    logic [7:0]                     m_cmd_data_q, m_cmd_data_d;
    logic                           m_cmd_valid_q, m_cmd_valid_d;
    logic                           trigger;
    logic                           to_expired;

    // Period counter; a shrinking period_i while running still wraps immediately.
    always_comb begin
        trigger      = 1'b0;
        period_cnt_d = period_cnt_q;
        if (!enable_i || (period_i == '0)) begin
            period_cnt_d = '0;
        end else if (period_cnt_q >= period_i - PERIOD_WIDTH'(1)) begin
            period_cnt_d = '0;
            trigger      = 1'b1;
        end else begin
            period_cnt_d = period_cnt_q + PERIOD_WIDTH'(1);
        end
    end

    assign to_expired = (to_cnt_q == ToW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        tx_time_d    = tx_time_q;
        cmd_byte_d   = cmd_byte_q;
        rtt_raw_d    = rtt_raw_q;
        elapsed_d    = elapsed_q;
        rtt_d        = rtt_q;
        node_delay_d = node_delay_q;
        first_done_d = first_done_q;
        meas_valid_d = 1'b0;
        timeout_d    = 1'b0;
        // A trigger outside IDLE is dropped and only reported.
        overrun_d    = trigger && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (trigger) state_d = StReq;
            end
            StReq: begin
                if (cmd_tx_ack_i) begin
                    tx_time_d  = current_time_i + TIMER_WIDTH'(TX_LATENCY);
                    cmd_byte_d = {6'b0, correct_override_i | ~first_done_q, 1'b1};
                    to_cnt_d   = '0;
                    state_d    = StWait;
                end
            end
            StWait: begin
                to_cnt_d = to_cnt_q + ToW'(1);
                if (to_expired) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else if (res_rx_start_i) begin
                    rtt_raw_d = current_time_i[31:0] - tx_time_q[31:0];
                    elapsed_d = '0;
                    state_d   = StRecv;
                end
            end
            StRecv: begin
                to_cnt_d = to_cnt_q + ToW'(1);
                if (s_res_valid_i) begin
                    for (int i = 0; i < int'(NODE_NUM); i++) begin
                        for (int b = 0; b < 4; b++) begin
                            if (s_res_pos_i == 16'(9 + 4 * i + b)) begin
                                elapsed_d[i][8*b +: 8] = s_res_data_i;
                            end
                        end
                    end
                end
                // Timeout wins over a simultaneous end of packet.
                if (to_expired) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else if (res_rx_error_i) begin
                    state_d = StIdle;
                end else if (res_rx_end_i) begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                rtt_d = rtt_raw_q;
                for (int i = 0; i < int'(NODE_NUM); i++) begin
                    // A slave reporting more elapsed time than the round trip saturates to 0.
                    if (elapsed_q[i] <= rtt_raw_q) begin
                        node_delay_d[i] = (rtt_raw_q - elapsed_q[i]) >> 1;
                    end else begin
                        node_delay_d[i] = '0;
                    end
                end
                meas_valid_d = 1'b1;
                first_done_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Payload server: answers from the frozen registers regardless of state.
    always_comb begin
        m_cmd_valid_d = 1'b0;
        m_cmd_data_d  = '0;
        if (s_cmd_valid_i) begin
            if (s_cmd_pos_i == 16'd0) begin
                m_cmd_valid_d = 1'b1;
                m_cmd_data_d  = cmd_byte_q;
            end
            for (int b = 0; b < 8; b++) begin
                if (s_cmd_pos_i == 16'(1 + b)) begin
                    m_cmd_valid_d = 1'b1;
                    m_cmd_data_d  = tx_time_q[8*b +: 8];
                end
            end
            for (int b = 0; b < 4; b++) begin
                if (s_cmd_pos_i == 16'(9 + b)) begin
                    m_cmd_valid_d = 1'b1;
                    m_cmd_data_d  = node_delay_q[0][8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            period_cnt_q  <= '0;
            to_cnt_q      <= '0;
            tx_time_q     <= '0;
            cmd_byte_q    <= '0;
            rtt_raw_q     <= '0;
            elapsed_q     <= '0;
            rtt_q         <= '0;
            node_delay_q  <= '0;
            first_done_q  <= 1'b0;
            meas_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
            m_cmd_data_q  <= '0;
            m_cmd_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            to_cnt_q      <= to_cnt_d;
            tx_time_q     <= tx_time_d;
            cmd_byte_q    <= cmd_byte_d;
            rtt_raw_q     <= rtt_raw_d;
            elapsed_q     <= elapsed_d;
            rtt_q         <= rtt_d;
            node_delay_q  <= node_delay_d;
            first_done_q  <= first_done_d;
            meas_valid_q  <= meas_valid_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
            m_cmd_data_q  <= m_cmd_data_d;
            m_cmd_valid_q <= m_cmd_valid_d;
        end
    end

    assign cmd_tx_request_o = (state_q == StReq);
    assign busy_o           = (state_q != StIdle);
    assign meas_valid_o     = meas_valid_q;
    assign overrun_o        = overrun_q;
    assign timeout_o        = timeout_q;
    assign rtt_o            = rtt_q;
    assign node_delay_o     = node_delay_q;
    assign m_cmd_data_o     = m_cmd_data_q;
    assign m_cmd_valid_o    = m_cmd_valid_q;

endmodule

// File: tb/tb_etherneco_synctimer_master.sv
// Randomized self-checking bench for etherneco_synctimer_master. The bench plays the
// framer and the ring, keeps a transaction-level model of the results and payload,
// and pins the model with hand-computed values.
module tb_etherneco_synctimer_master;

    localparam int unsigned NN = 4;
    localparam int unsigned TO = 50;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [31:0]        period;
    logic               correct_override;
    logic [63:0]        current_time;
    logic               cmd_tx_request;
    logic               cmd_tx_ack;
    logic [15:0]        s_cmd_pos;
    logic               s_cmd_valid;
    logic [7:0]         m_cmd_data;
    logic               m_cmd_valid;
    logic               res_rx_start;
    logic               res_rx_end;
    logic               res_rx_error;
    logic [15:0]        s_res_pos;
    logic [7:0]         s_res_data;
    logic               s_res_valid;
    logic               busy;
    logic               meas_valid;
    logic               overrun;
    logic               timeout;
    logic [31:0]        rtt;
    logic [NN*32-1:0]   node_delay;

    always #5 clk = ~clk;

    etherneco_synctimer_master #(
        .TIMER_WIDTH (64),
        .NODE_NUM    (NN),
        .PERIOD_WIDTH(32),
        .TIMEOUT     (TO),
        .TX_LATENCY  (0)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .enable_i          (enable),
        .period_i          (period),
        .correct_override_i(correct_override),
        .current_time_i    (current_time),
        .cmd_tx_request_o  (cmd_tx_request),
        .cmd_tx_ack_i      (cmd_tx_ack),
        .s_cmd_pos_i       (s_cmd_pos),
        .s_cmd_valid_i     (s_cmd_valid),
        .m_cmd_data_o      (m_cmd_data),
        .m_cmd_valid_o     (m_cmd_valid),
        .res_rx_start_i    (res_rx_start),
        .res_rx_end_i      (res_rx_end),
        .res_rx_error_i    (res_rx_error),
        .s_res_pos_i       (s_res_pos),
        .s_res_data_i      (s_res_data),
        .s_res_valid_i     (s_res_valid),
        .busy_o            (busy),
        .meas_valid_o      (meas_valid),
        .overrun_o         (overrun),
        .timeout_o         (timeout),
        .rtt_o             (rtt),
        .node_delay_o      (node_delay)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int meas_cnt = 0;
    int ovr_cnt = 0;
    int to_cnt = 0;
    bit mon_en = 1'b0;

    // Model state: what the DUT must currently hold.
    logic [63:0] exp_tx;
    logic [7:0]  exp_cmd;
    logic [31:0] exp_rtt;
    logic [31:0] exp_nd [NN];
    logic [31:0] exp_raw;
    bit          exp_first_done;
    logic [31:0] cur_el [NN];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    function automatic logic [NN*32-1:0] exp_nd_packed();
        logic [NN*32-1:0] r;
        for (int i = 0; i < int'(NN); i++) r[32*i +: 32] = exp_nd[i];
        return r;
    endfunction

    function automatic logic [31:0] delay_of(input logic [31:0] raw, input logic [31:0] el);
        return (el <= raw) ? (raw - el) / 2 : 32'd0;
    endfunction

    task automatic model_reset();
        exp_tx = '0;
        exp_cmd = '0;
        exp_rtt = '0;
        exp_raw = '0;
        exp_first_done = 1'b0;
        for (int i = 0; i < int'(NN); i++) exp_nd[i] = '0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare of the result registers plus pulse accounting.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (meas_valid) meas_cnt <= meas_cnt + 1;
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (timeout) to_cnt <= to_cnt + 1;
            chk("rtt", 128'(rtt), 128'(exp_rtt));
            chk("node_delay", 128'(node_delay), 128'(exp_nd_packed()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int rise);
        rise = -1;
        for (int k = 0; k < 400; k++) begin
            if (cmd_tx_request) begin
                rise = cyc;
                break;
            end
            tick();
        end
        if (rise < 0) chk("req_wait_expired", 128'(0), 128'(1));
    endtask

    task automatic do_ack(input logic [63:0] t, input bit ovr);
        current_time = t;
        correct_override = ovr;
        cmd_tx_ack = 1'b1;
        tick();
        cmd_tx_ack = 1'b0;
        exp_tx = t;
        exp_cmd = {6'b0, ovr | ~exp_first_done, 1'b1};
        chk("req_drop", 128'(cmd_tx_request), 128'(0));
        chk("busy_after_ack", 128'(busy), 128'(1));
    endtask

    task automatic read_payload(input logic [15:0] pos, output logic [7:0] d);
        bit         ev;
        logic [7:0] ed;
        int         p;
        p = int'(pos);
        ev = 1'b1;
        ed = '0;
        if (p == 0) ed = exp_cmd;
        else if (p <= 8) ed = exp_tx[8*(p-1) +: 8];
        else if (p <= 12) ed = exp_nd[0][8*(p-9) +: 8];
        else ev = 1'b0;
        s_cmd_pos = pos;
        s_cmd_valid = 1'b1;
        tick();
        s_cmd_valid = 1'b0;
        chk("payload_valid", 128'(m_cmd_valid), 128'(ev));
        if (ev) chk("payload_data", 128'(m_cmd_data), 128'(ed));
        d = m_cmd_data;
    endtask

    task automatic do_start(input logic [63:0] t);
        current_time = t;
        res_rx_start = 1'b1;
        tick();
        res_rx_start = 1'b0;
        exp_raw = t[31:0] - exp_tx[31:0];
    endtask

    task automatic send_bytes(input int first, input int last);
        int gaps = 0;
        for (int p = first; p <= last; p++) begin
            if (gaps < 3 && $urandom_range(7) == 0) begin
                tick();
                gaps++;
            end
            s_res_pos = 16'(p);
            if (p >= 9 && p < 9 + 4 * int'(NN)) s_res_data = cur_el[(p-9)/4][8*((p-9)%4) +: 8];
            else s_res_data = 8'($urandom);
            s_res_valid = 1'b1;
            tick();
            s_res_valid = 1'b0;
        end
    endtask

    task automatic finish_resp(input bit err);
        res_rx_end = 1'b1;
        res_rx_error = err;
        tick();
        res_rx_end = 1'b0;
        res_rx_error = 1'b0;
        if (err) begin
            chk("err_to_idle", 128'(busy), 128'(0));
        end else begin
            chk("calc_busy", 128'(busy), 128'(1));
            chk("calc_no_meas_yet", 128'(meas_valid), 128'(0));
            tick();
            chk("meas_pulse", 128'(meas_valid), 128'(1));
            chk("idle_after_calc", 128'(busy), 128'(0));
            exp_rtt = exp_raw;
            for (int i = 0; i < int'(NN); i++) exp_nd[i] = delay_of(exp_raw, cur_el[i]);
            exp_first_done = 1'b1;
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int          c0, rise, last_rise, m0, o0, t0;
        logic [7:0]  d;
        logic [63:0] lit64, at, st;
        bit          err;

        rst_n = 1'b0;
        enable = 1'b0;
        period = 32'd100;
        correct_override = 1'b0;
        current_time = '0;
        cmd_tx_ack = 1'b0;
        s_cmd_pos = '0;
        s_cmd_valid = 1'b0;
        res_rx_start = 1'b0;
        res_rx_end = 1'b0;
        res_rx_error = 1'b0;
        s_res_pos = '0;
        s_res_data = '0;
        s_res_valid = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_req", 128'(cmd_tx_request), 128'(0));
        chk("rst_mvalid", 128'(m_cmd_valid), 128'(0));

        // First trigger lands exactly one period after enable.
        enable = 1'b1;
        c0 = cyc;
        wait_req(rise);
        chk("first_req_cycle", 128'(rise - c0), 128'(100));
        last_rise = rise;
        m0 = meas_cnt; o0 = ovr_cnt; t0 = to_cnt;

        // Transaction 1: fixed values.
        do_ack(64'h1000, 1'b0);
        lit64 = 64'h1000;
        read_payload(16'd0, d);
        chk("lit_pos0_first", 128'(d), 128'(8'h03));
        for (int p = 1; p <= 8; p++) begin
            read_payload(16'(p), d);
            chk("lit_txtime_byte", 128'(d), 128'(lit64[8*(p-1) +: 8]));
        end
        for (int p = 9; p <= 12; p++) begin
            read_payload(16'(p), d);
            chk("lit_offset_zero", 128'(d), 128'(0));
        end
        read_payload(16'd13, d);
        chk("lit_pos13_invalid", 128'(m_cmd_valid), 128'(0));
        cur_el[0] = 32'h300; cur_el[1] = 32'h100; cur_el[2] = 32'h500; cur_el[3] = 32'h400;
        do_start(64'h1400);
        send_bytes(5, 27);
        finish_resp(1'b0);
        chk("lit_rtt", 128'(rtt), 128'(32'h400));
        chk("lit_nd0", 128'(node_delay[31:0]), 128'(32'h80));
        chk("lit_nd1", 128'(node_delay[63:32]), 128'(32'h180));
        chk("lit_nd2_sat", 128'(node_delay[95:64]), 128'(0));
        chk("lit_nd3_equal", 128'(node_delay[127:96]), 128'(0));
        chk("txn1_meas_count", 128'(meas_cnt - m0), 128'(1));
        chk("txn1_no_overrun", 128'(ovr_cnt - o0), 128'(0));

        // Transaction 2: offset feedback and 32-bit wrap of the round trip.
        wait_req(rise);
        chk("req_period", 128'(rise - last_rise), 128'(100));
        last_rise = rise;
        do_ack(64'h1_FFFF_FFF0, 1'b0);
        read_payload(16'd0, d);
        chk("lit_pos0_second", 128'(d), 128'(8'h01));
        read_payload(16'd9, d);
        chk("lit_offset_b0", 128'(d), 128'(8'h80));
        for (int p = 10; p <= 12; p++) begin
            read_payload(16'(p), d);
            chk("lit_offset_hi", 128'(d), 128'(0));
        end
        cur_el[0] = 32'h10; cur_el[1] = 32'h20; cur_el[2] = 32'h21; cur_el[3] = 32'h0;
        do_start(64'h2_0000_0010);
        send_bytes(5, 27);
        finish_resp(1'b0);
        chk("lit_rtt_wrap", 128'(rtt), 128'(32'h20));
        chk("lit_nd0_wrap", 128'(node_delay[31:0]), 128'(32'h8));

        // Transaction 3: errored response leaves results alone.
        wait_req(rise);
        chk("req_period", 128'(rise - last_rise), 128'(100));
        last_rise = rise;
        m0 = meas_cnt;
        do_ack(64'h5000, 1'b1);
        for (int i = 0; i < int'(NN); i++) cur_el[i] = $urandom;
        do_start(64'h9000);
        send_bytes(5, 20);
        finish_resp(1'b1);
        chk("lit_rtt_kept", 128'(rtt), 128'(32'h20));
        chk("err_no_meas", 128'(meas_cnt - m0), 128'(0));

        // Randomized transactions.
        for (int n = 0; n < 12; n++) begin
            wait_req(rise);
            chk("req_period", 128'(rise - last_rise), 128'(100));
            last_rise = rise;
            m0 = meas_cnt; o0 = ovr_cnt; t0 = to_cnt;
            repeat ($urandom_range(3)) tick();
            at = {$urandom, $urandom};
            if ($urandom_range(1) == 1) st = at + 64'($urandom_range(65535));
            else st = {$urandom, $urandom};
            err = ($urandom_range(4) == 0);
            do_ack(at, 1'($urandom_range(1)));
            for (int k = 0; k < int'($urandom_range(5)); k++) begin
                if ($urandom_range(3) == 0) read_payload(16'($urandom), d);
                else read_payload(16'($urandom_range(15)), d);
            end
            repeat ($urandom_range(2)) tick();
            exp_raw = st[31:0] - at[31:0];
            for (int i = 0; i < int'(NN); i++) begin
                case ($urandom_range(3))
                    0: cur_el[i] = $urandom;
                    1: cur_el[i] = exp_raw;
                    2: cur_el[i] = exp_raw + 32'd1;
                    default: cur_el[i] = $urandom_range(exp_raw, 0);
                endcase
            end
            do_start(st);
            send_bytes(5, 27);
            finish_resp(err);
            for (int k = 0; k < 3; k++) read_payload(16'($urandom_range(13)), d);
            chk("rnd_meas_count", 128'(meas_cnt - m0), 128'(err ? 0 : 1));
            chk("rnd_no_overrun", 128'(ovr_cnt - o0), 128'(0));
            chk("rnd_no_timeout", 128'(to_cnt - t0), 128'(0));
        end

        // Ack while idle is ignored.
        enable = 1'b0;
        repeat (2) tick();
        current_time = {$urandom, $urandom};
        cmd_tx_ack = 1'b1;
        tick();
        cmd_tx_ack = 1'b0;
        chk("idle_ack_busy", 128'(busy), 128'(0));
        for (int p = 0; p <= 8; p++) read_payload(16'(p), d);

        // Overrun while the framer stalls, then timeout with no response.
        period = 32'd10;
        enable = 1'b1;
        c0 = cyc;
        wait_req(rise);
        chk("short_period_req", 128'(rise - c0), 128'(10));
        m0 = meas_cnt; o0 = ovr_cnt; t0 = to_cnt;
        repeat (25) tick();
        enable = 1'b0;
        do_ack({$urandom, $urandom}, 1'b1);
        chk("overrun_count", 128'(ovr_cnt - o0), 128'(2));
        repeat (TO - 1) tick();
        chk("pre_timeout_pulse", 128'(timeout), 128'(0));
        chk("pre_timeout_busy", 128'(busy), 128'(1));
        tick();
        chk("timeout_pulse", 128'(timeout), 128'(1));
        chk("timeout_idle", 128'(busy), 128'(0));
        tick();
        chk("timeout_count", 128'(to_cnt - t0), 128'(1));
        res_rx_end = 1'b1;
        tick();
        res_rx_end = 1'b0;
        repeat (30) tick();
        chk("timeout_no_meas", 128'(meas_cnt - m0), 128'(0));
        chk("single_txn", 128'(cmd_tx_request), 128'(0));
        read_payload(16'd0, d);
        chk("lit_pos0_override", 128'(d), 128'(8'h03));

        // Asynchronous reset while receiving.
        period = 32'd100;
        enable = 1'b1;
        wait_req(rise);
        do_ack({$urandom, $urandom}, 1'b0);
        for (int i = 0; i < int'(NN); i++) cur_el[i] = $urandom;
        do_start({$urandom, $urandom});
        send_bytes(5, 12);
        s_cmd_pos = 16'd1;
        s_cmd_valid = 1'b1;
        tick();
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_req", 128'(cmd_tx_request), 128'(0));
        chk("arst_rtt", 128'(rtt), 128'(0));
        chk("arst_nd", 128'(node_delay), 128'(0));
        chk("arst_mvalid", 128'(m_cmd_valid), 128'(0));
        chk("arst_mdata", 128'(m_cmd_data), 128'(0));
        chk("arst_meas", 128'(meas_valid), 128'(0));
        s_cmd_valid = 1'b0;
        enable = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        read_payload(16'd0, d);
        read_payload(16'd3, d);

        // First transaction after reset asks for an overwrite again.
        enable = 1'b1;
        c0 = cyc;
        wait_req(rise);
        chk("post_reset_req", 128'(rise - c0), 128'(100));
        do_ack(64'h2000, 1'b0);
        read_payload(16'd0, d);
        chk("lit_pos0_after_reset", 128'(d), 128'(8'h03));
        for (int i = 0; i < int'(NN); i++) cur_el[i] = 32'(i) * 32'h40;
        do_start(64'h2200);
        send_bytes(5, 27);
        finish_resp(1'b0);
        chk("lit_nd1_after_reset", 128'(node_delay[63:32]), 128'(32'hE0));
        enable = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
